// File: rtl/eth_tx.sv
// eth_tx: transmit side of a switch port; drains the packet FIFO onto the output bus with framing checks and inter-packet gap.
// Latency: rd_en to o_valid is 2 cycles; steady-state throughput 1 word/cycle.
// Backpressure: i_stall freezes the output register; the one word already in flight parks in a 1-entry skid.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   rd_data/empty      FIFO read side; rd_data = {data[31:0], start, end}, valid the cycle after rd_en
//   rd_en              FIFO read enable (never asserted while empty)
//   i_stall            downstream stall; output bus holds while high and o_valid
//   o_data/o_start/o_end/o_valid   output packet bus
//   pkt_cnt            count of transferred end words, wraps
//   err_drop           one-cycle pulse on a framing error (orphan word dropped or packet truncated)
module eth_tx #(
    parameter int IPG_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [33:0]      rd_data,
    input  logic             empty,
    output logic             rd_en,
    input  logic             i_stall,
    output logic [31:0]      o_data,
    output logic             o_start,
    output logic             o_end,
    output logic             o_valid,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             err_drop
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // The cycle the end word transfers already counts as the first gap cycle,
    // and the last gap cycle is the one in which the next start word loads
    // (it is presented one cycle later). So the GAP state itself only needs
    // IPG_CYCLES-1 further blocking cycles.
    localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (IPG_CYCLES > 0) ? GAP_W'(IPG_CYCLES - 1) : '0;

    state_t           state, state_nxt, cur;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             run;
    logic             rd_pend;
    logic             skid_vld, skid_vld_nxt;
    logic [33:0]      skid_dat;

    logic [33:0]      cand;
    logic             cand_vld;
    logic             xfer, out_free, end_xfer;
    logic             load, drop, take, err_nxt;

    always_comb begin
        cand_vld = skid_vld | rd_pend;
        // skid is older than anything arriving, so it always goes first
        cand     = skid_vld ? skid_dat : rd_data;
        xfer     = o_valid & ~i_stall;
        out_free = ~o_valid | ~i_stall;
        end_xfer = xfer & o_end;

        state_nxt = state;
        gap_nxt   = gap_cnt;
        cur       = state;

        // cur is the state the current candidate is judged against: the
        // packet ends the moment its end word transfers, not a cycle later.
        if (end_xfer) begin
            if (IPG_CYCLES == 0) begin
                state_nxt = IDLE;
                cur       = IDLE;
            end else begin
                state_nxt = GAP;
                cur       = GAP;
                gap_nxt   = GAP_LOAD;
            end
        end else if (state == GAP) begin
            if (gap_cnt == '0) begin
                state_nxt = IDLE;
                cur       = IDLE;
            end else begin
                gap_nxt = gap_cnt - 1'b1;
            end
        end

        load    = 1'b0;
        drop    = 1'b0;
        err_nxt = 1'b0;
        if (cand_vld) begin
            case (cur)
                IDLE: begin
                    if (!cand[1]) begin
                        drop    = 1'b1;
                        err_nxt = 1'b1;
                    end else if (out_free) begin
                        load = 1'b1;
                    end
                end
                PKT: begin
                    if (out_free) begin
                        load    = 1'b1;
                        // a start inside a packet truncates the old one
                        err_nxt = cand[1];
                    end
                end
                default: ;
            endcase
        end

        // Once a word sits in the output register the packet is in flight;
        // the move to GAP happens when its end word actually transfers.
        if (load) begin
            state_nxt = PKT;
        end

        take = load | drop;

        // A read is only issued when the skid will be empty next cycle, so a
        // held skid word and an arriving word never coincide.
        skid_vld_nxt = skid_vld;
        if (take) begin
            skid_vld_nxt = 1'b0;
        end else if (rd_pend) begin
            skid_vld_nxt = 1'b1;
        end

        rd_en = run & ~empty & ~skid_vld & ~(i_stall & o_valid) & ~skid_vld_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            run      <= 1'b0;
            rd_pend  <= 1'b0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
            o_data   <= '0;
            o_start  <= 1'b0;
            o_end    <= 1'b0;
            o_valid  <= 1'b0;
            pkt_cnt  <= '0;
            err_drop <= 1'b0;
        end else begin
            // holds reads off for the first cycle after reset release
            run      <= 1'b1;
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            rd_pend  <= rd_en;
            skid_vld <= skid_vld_nxt;
            err_drop <= err_nxt;

            if (!take && rd_pend) begin
                skid_dat <= rd_data;
            end

            if (end_xfer) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end

            if (load) begin
                o_data  <= cand[33:2];
                o_start <= cand[1];
                o_end   <= cand[0];
                o_valid <= 1'b1;
            end else if (xfer) begin
                o_data  <= '0;
                o_start <= 1'b0;
                o_end   <= 1'b0;
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eth_tx.sv
// tb_eth_tx: self-checking bench for eth_tx against a packet-level reference model.
// Latency: n/a (bench).
// Backpressure: drives i_stall directly; the FIFO model answers rd_en one cycle later.
module tb_eth_tx;

    localparam int IPG = 2;
    localparam int CW  = 3;

    logic          clk     = 1'b0;
    logic          rstn    = 1'b0;
    logic [33:0]   rd_data = '0;
    logic          empty   = 1'b1;
    logic          rd_en;
    logic          i_stall = 1'b0;
    logic [31:0]   o_data;
    logic          o_start;
    logic          o_end;
    logic          o_valid;
    logic [CW-1:0] pkt_cnt;
    logic          err_drop;

    eth_tx #(.IPG_CYCLES(IPG), .CNT_W(CW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rd_data  (rd_data),
        .empty    (empty),
        .rd_en    (rd_en),
        .i_stall  (i_stall),
        .o_data   (o_data),
        .o_start  (o_start),
        .o_end    (o_end),
        .o_valid  (o_valid),
        .pkt_cnt  (pkt_cnt),
        .err_drop (err_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rel_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: rd_en seen at the edge, data presented just after it.
    logic [33:0] fifo_q[$];
    always @(posedge clk) begin : fifo_model
        logic take;
        take = rd_en;
        #1;
        if (take && fifo_q.size() != 0) rd_data = fifo_q.pop_front();
        empty = (fifo_q.size() == 0);
    end

    // Reference model: packet-level framing rules on the word stream.
    logic [33:0] exp_q[$];
    int exp_err  = 0;
    int exp_pkts = 0;
    bit m_in_pkt = 1'b0;

    // Monitor: transfers, error pulses, protocol invariants.
    typedef struct {
        logic [33:0] w;
        int          c;
    } obs_t;
    obs_t obs_q[$];
    int err_seen, err_cyc, first_rd_cyc, rd_empty_viol, stab_viol, stray_flags;
    logic [34:0] prev_out;
    bit prev_hold;

    always @(negedge clk) begin : monitor
        obs_t o;
        if (!rstn) begin
            prev_hold = 1'b0;
        end else begin
            if (o_valid && !i_stall) begin
                o.w = {o_data, o_start, o_end};
                o.c = cyc;
                obs_q.push_back(o);
            end
            if (err_drop) begin
                err_seen++;
                err_cyc = cyc;
            end
            if (rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (rd_en && empty) rd_empty_viol++;
            if (!o_valid && (o_start || o_end)) stray_flags++;
            if (prev_hold && ({o_valid, o_data, o_start, o_end} !== prev_out)) stab_viol++;
            prev_hold = o_valid && i_stall;
            prev_out  = {o_valid, o_data, o_start, o_end};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        i_stall = 1'b0;
        fifo_q.delete();
        empty = 1'b1;
        exp_q.delete();
        obs_q.delete();
        exp_err = 0; exp_pkts = 0; m_in_pkt = 1'b0;
        err_seen = 0; err_cyc = -1; first_rd_cyc = -1;
        rd_empty_viol = 0; stab_viol = 0; stray_flags = 0;
        repeat (2) tick();
    endtask

    task automatic release_reset();
        rstn    = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic push_word(input logic [31:0] d, input logic s, input logic e);
        logic [33:0] w;
        w = {d, s, e};
        fifo_q.push_back(w);
        empty = 1'b0;
        if (!s && !m_in_pkt) begin
            exp_err++;
        end else begin
            if (s && m_in_pkt) exp_err++;
            exp_q.push_back(w);
            m_in_pkt = !e;
            if (e) exp_pkts++;
        end
    endtask

    task automatic push_pkt(input int len);
        for (int i = 0; i < len; i++) push_word($urandom, (i == 0), (i == len - 1));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || obs_q.size() < exp_q.size() || o_valid) && n < budget) begin
            tick();
            n++;
        end
        repeat (IPG + 3) tick();
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: seen %0d words, required %0d", obs_q.size(), exp_q.size());
        end
    endtask

    // -1 when the transferred stream matches the model, else first bad index (-2: length)
    function automatic int stream_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (obs_q[i].w !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        push_pkt(2);
        tick();
        checks++;
        if ({rd_en, o_valid, o_start, o_end, err_drop, o_data, pkt_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h, required 0",
                     {rd_en, o_valid, o_start, o_end, err_drop, o_data, pkt_cnt});
        end
        release_reset();
        @(negedge clk);
        checks++;
        if (rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rd_en: got %b, required 0", rd_en);
        end
        wait_drain(50);
    endtask

    task automatic test_basic();
        int d, c0, c3;
        do_reset();
        push_pkt(4);
        release_reset();
        wait_drain(50);
        checks++;
        if (first_rd_cyc != rel_cyc + 1) begin
            errors++;
            $display("FAIL basic_first_rd_en: cycle %0d, required %0d", first_rd_cyc - rel_cyc, 1);
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL basic_stream: diff at %0d, seen %0d words, required %0d", d, obs_q.size(), exp_q.size());
        end
        c0 = (obs_q.size() > 0) ? obs_q[0].c - rel_cyc : -1;
        c3 = (obs_q.size() > 3) ? obs_q[3].c - rel_cyc : -1;
        checks++;
        if (c0 != 3 || c3 != 6) begin
            errors++;
            $display("FAIL basic_timing: first/last at %0d/%0d, required 3/6", c0, c3);
        end
        checks++;
        if (stray_flags != 0) begin
            errors++;
            $display("FAIL basic_stray_flags: %0d, required 0", stray_flags);
        end
        checks++;
        if (pkt_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL basic_pkt_cnt: got %0d, required 1", pkt_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int d, gap;
        do_reset();
        push_pkt(3);
        push_pkt(3);
        release_reset();
        wait_drain(60);
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL b2b_stream: diff at %0d, seen %0d words, required %0d", d, obs_q.size(), exp_q.size());
        end
        gap = (obs_q.size() > 3) ? obs_q[3].c - obs_q[2].c - 1 : -1;
        checks++;
        if (gap != IPG) begin
            errors++;
            $display("FAIL b2b_gap: %0d idle cycles, required %0d", gap, IPG);
        end
        checks++;
        if (pkt_cnt !== CW'(2)) begin
            errors++;
            $display("FAIL b2b_pkt_cnt: got %0d, required 2", pkt_cnt);
        end
    endtask

    task automatic test_stall();
        int d, n;
        bit found;
        logic [34:0] held;
        do_reset();
        push_pkt(8);
        release_reset();
        found = 1'b0;
        n = 0;
        while (!found && n < 30) begin
            tick();
            n++;
            if (o_valid && {o_data, o_start, o_end} === exp_q[1]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stall_word2_seen: not seen within %0d cycles", n);
        end
        i_stall = 1'b1;
        held = {o_valid, o_data, o_start, o_end};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({o_valid, o_data, o_start, o_end} !== held) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %h, required %h", k, {o_valid, o_data, o_start, o_end}, held);
            end
            tick();
        end
        i_stall = 1'b0;
        wait_drain(60);
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL stall_stream: diff at %0d, seen %0d words, required %0d", d, obs_q.size(), exp_q.size());
        end
        checks++;
        if (rd_empty_viol != 0) begin
            errors++;
            $display("FAIL stall_rd_en_empty: %0d cycles, required 0", rd_empty_viol);
        end
        checks++;
        if (pkt_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL stall_pkt_cnt: got %0d, required 1", pkt_cnt);
        end
    endtask

    task automatic test_drop();
        int d, c0;
        do_reset();
        push_word($urandom, 1'b0, 1'b0);
        push_word(32'hDEADBEEF, 1'b1, 1'b1);
        release_reset();
        wait_drain(40);
        checks++;
        if (err_seen != exp_err) begin
            errors++;
            $display("FAIL drop_err_pulses: got %0d, required %0d", err_seen, exp_err);
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL drop_stream: diff at %0d, seen %0d words, required %0d", d, obs_q.size(), exp_q.size());
        end
        c0 = (obs_q.size() > 0) ? obs_q[0].c : -1;
        checks++;
        if (c0 != err_cyc + 1) begin
            errors++;
            $display("FAIL drop_timing: word at %0d, required %0d", c0, err_cyc + 1);
        end
        checks++;
        if (pkt_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL drop_pkt_cnt: got %0d, required 1", pkt_cnt);
        end
    endtask

    task automatic test_truncate();
        int d;
        do_reset();
        push_word($urandom, 1'b1, 1'b0);
        push_word($urandom, 1'b0, 1'b0);
        push_word($urandom, 1'b1, 1'b0);
        push_word($urandom, 1'b0, 1'b1);
        release_reset();
        wait_drain(40);
        checks++;
        if (err_seen != exp_err) begin
            errors++;
            $display("FAIL trunc_err_pulses: got %0d, required %0d", err_seen, exp_err);
        end
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL trunc_stream: diff at %0d, seen %0d words, required %0d", d, obs_q.size(), exp_q.size());
        end
        checks++;
        if (pkt_cnt !== CW'(exp_pkts)) begin
            errors++;
            $display("FAIL trunc_pkt_cnt: got %0d, required %0d", pkt_cnt, exp_pkts);
        end
    endtask

    task automatic test_random();
        logic [33:0] pend[$];
        logic [33:0] w;
        int d, n, kind, len, gap_viol;
        do_reset();
        for (int p = 0; p < 30; p++) begin
            kind = $urandom_range(0, 9);
            len  = $urandom_range(1, 5);
            if (kind == 0) pend.push_back({$urandom, 2'b00});
            for (int i = 0; i < len; i++)
                pend.push_back({$urandom, (i == 0), (i == len - 1 && kind != 1)});
        end
        pend.push_back({$urandom, 2'b10});
        pend.push_back({$urandom, 2'b01});
        release_reset();
        n = 0;
        while ((pend.size() != 0 || fifo_q.size() != 0 || obs_q.size() < exp_q.size()) && n < 4000) begin
            if (pend.size() != 0 && $urandom_range(0, 2) != 0) begin
                w = pend.pop_front();
                push_word(w[33:2], w[1], w[0]);
            end
            i_stall = ($urandom_range(0, 3) == 0);
            tick();
            n++;
        end
        i_stall = 1'b0;
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL rand_timeout: seen %0d words, required %0d", obs_q.size(), exp_q.size());
        end
        wait_drain(100);
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL rand_stream: diff at %0d, seen %0d words, required %0d", d, obs_q.size(), exp_q.size());
        end
        checks++;
        if (err_seen != exp_err) begin
            errors++;
            $display("FAIL rand_err_pulses: got %0d, required %0d", err_seen, exp_err);
        end
        checks++;
        if (pkt_cnt !== CW'(exp_pkts)) begin
            errors++;
            $display("FAIL rand_pkt_cnt: got %0d, required %0d (mod %0d)", pkt_cnt, exp_pkts, 1 << CW);
        end
        checks++;
        if (rd_empty_viol != 0 || stab_viol != 0 || stray_flags != 0) begin
            errors++;
            $display("FAIL rand_invariants: rd_en_empty %0d stall_unstable %0d stray %0d, required 0 0 0",
                     rd_empty_viol, stab_viol, stray_flags);
        end
        gap_viol = 0;
        for (int i = 1; i < obs_q.size(); i++)
            if (obs_q[i - 1].w[0] && (obs_q[i].c - obs_q[i - 1].c) < IPG + 1) gap_viol++;
        checks++;
        if (gap_viol != 0) begin
            errors++;
            $display("FAIL rand_ipg: %0d short gaps, required 0", gap_viol);
        end
    endtask

    task automatic test_async_reset();
        int d, n;
        do_reset();
        push_pkt(8);
        release_reset();
        n = 0;
        while (obs_q.size() < 2 && n < 30) begin
            tick();
            n++;
        end
        i_stall = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({rd_en, o_valid, o_start, o_end, err_drop, o_data, pkt_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h, required 0",
                     {rd_en, o_valid, o_start, o_end, err_drop, o_data, pkt_cnt});
        end
        do_reset();
        push_pkt(2);
        release_reset();
        wait_drain(40);
        d = stream_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL async_after_stream: diff at %0d, seen %0d words, required %0d", d, obs_q.size(), exp_q.size());
        end
        checks++;
        if (pkt_cnt !== CW'(1) || err_seen != 0) begin
            errors++;
            $display("FAIL async_after_counts: pkt_cnt %0d err %0d, required 1 0", pkt_cnt, err_seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_drop();
        test_truncate();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
